ebus_pi_agent: RTL and testbench



---
 rtl/ebus_pi_pkg.sv | 24 ++
 rtl/ebus_pi_agent_pi_pend_ctr.sv | 23 ++
 rtl/ebus_pi_agent.sv | 149 ++++++++++++++
 tb/tb_ebus_pi_agent.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ebus_pi_pkg.sv
// Shared definitions for the EBUS priority-interrupt agent: FSM states,
// EBUS function codes and PI function codes carried during SELECT.
package ebus_pi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL,
    ST_SEL,
    ST_XFER,
    ST_WAITREL
  } pi_state_t;

  localparam logic [2:0] EBUS_FUNC_POLL   = 3'b001;
  localparam logic [2:0] EBUS_FUNC_SELECT = 3'b010;

  localparam logic [2:0] PI_FN_READ_VECTOR = 3'b001;
  localparam logic [2:0] PI_FN_CLEAR       = 3'b010;

  // Only completed READ_VECTOR and CLEAR services retire a pending interrupt.
  function automatic logic fn_retires(input logic [2:0] fn);
    return (fn == PI_FN_READ_VECTOR) || (fn == PI_FN_CLEAR);
  endfunction

endpackage

// File: rtl/ebus_pi_agent_pi_pend_ctr.sv
// Saturating 2-bit up/down pending-interrupt counter with synchronous clear.
module pi_pend_ctr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !dec) begin
      if (count != 2'd3) count <= count + 2'd1;
    end else if (dec && !inc) begin
      if (count != 2'd0) count <= count - 2'd1;
    end
  end

endmodule

// File: rtl/ebus_pi_agent.sv
// Device-side EBUS PI agent: requests, answers POLL, serves SELECT/XFER.
// Optional watchdog enabled by defining PI_AGENT_TIMEOUT_EN.
module ebus_pi_agent
  import ebus_pi_pkg::*;
#(
  parameter int unsigned PHY_NO  = 0,
  parameter logic [35:0] VECTOR  = 36'o0,
  parameter int unsigned TMO_CYC = 255
) (
  input  logic        clk,
  input  logic        RESET_N,
  input  logic        dev_irq,
  input  logic        cono_wr,
  input  logic [0:17] cono_data,
  input  logic        ebus_demand,
  input  logic [0:2]  ebus_func,
  input  logic [0:2]  ebus_pi_lvl,
  input  logic [0:35] ebus_data_in,
  output logic [1:7]  pi_out,
  output logic [0:35] ebus_data_out,
  output logic        ebus_drive,
  output logic        ebus_xfer,
  output logic [0:2]  pia,
  output logic [0:1]  pending,
  output logic        tmo
);

  localparam logic [3:0] PHY = 4'(PHY_NO);

  pi_state_t  state, state_n;
  logic [2:0] pia_q;
  logic       en_q;
  logic [2:0] fn_q;
  logic [1:0] pend_cnt;
  logic       cono_clr;
  logic       req;
  logic       dec;
  logic       sel_hit;
  logic       tmo_hit;
  logic       unused_bits;

  assign unused_bits = ^{cono_data[0:12], ebus_data_in[0:2], ebus_data_in[6],
                         ebus_data_in[11:35]};

  assign cono_clr = cono_wr && cono_data[13];
  assign sel_hit  = ebus_demand && (ebus_func == EBUS_FUNC_SELECT) &&
                    (ebus_data_in[7:10] == PHY);
  assign req      = en_q && (pend_cnt != 2'd0) && (pia_q != 3'd0) &&
                    ((state == ST_IDLE) || (state == ST_POLL));
  assign pia      = pia_q;
  assign pending  = pend_cnt;

  pi_pend_ctr u_pend (
    .clk   (clk),
    .rst_n (RESET_N),
    .clr   (cono_clr),
    .inc   (dev_irq),
    .dec   (dec),
    .count (pend_cnt)
  );

  // CONO is accepted in any state; the state term in req defers its effect.
  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      state <= ST_IDLE;
      pia_q <= '0;
      en_q  <= 1'b0;
      fn_q  <= '0;
    end else begin
      state <= state_n;
      if (cono_wr) begin
        pia_q <= cono_data[15:17];
        en_q  <= cono_data[14];
      end
      if ((state == ST_POLL) && sel_hit) fn_q <= ebus_data_in[3:5];
    end
  end

  always_comb begin
    state_n       = state;
    dec           = 1'b0;
    ebus_xfer     = 1'b0;
    ebus_drive    = 1'b0;
    ebus_data_out = '0;
    case (state)
      ST_IDLE: begin
        if (ebus_demand && (ebus_func == EBUS_FUNC_POLL) &&
            (ebus_pi_lvl == pia_q) && req)
          state_n = ST_POLL;
      end
      ST_POLL: begin
        ebus_drive            = 1'b1;
        ebus_data_out[PHY_NO] = 1'b1;
        if (!ebus_demand)                        state_n = ST_IDLE;
        else if (ebus_func == EBUS_FUNC_SELECT)  state_n = sel_hit ? ST_SEL : ST_IDLE;
      end
      ST_SEL: state_n = ST_XFER;
      ST_XFER: begin
        ebus_xfer  = 1'b1;
        ebus_drive = 1'b1;
        if (fn_q == PI_FN_READ_VECTOR) ebus_data_out = VECTOR;
        if (!ebus_demand) begin
          state_n = ST_WAITREL;
          dec     = fn_retires(fn_q);
        end
      end
      ST_WAITREL: state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
    if (tmo_hit) begin
      state_n = ST_WAITREL;
      dec     = 1'b0;
    end
  end

  always_comb begin
    pi_out = '0;
    for (int unsigned i = 1; i <= 7; i++)
      if (req && (pia_q == 3'(i))) pi_out[i] = 1'b1;
  end

`ifdef PI_AGENT_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       tmo_q;

  assign tmo_hit = ((state == ST_POLL) || (state == ST_XFER)) &&
                   (tmo_cnt == 8'(TMO_CYC));
  assign tmo     = tmo_q;

  // Counter holds through SEL so the whole service is bounded.
  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else begin
      if (state == ST_IDLE)                             tmo_cnt <= '0;
      else if ((state == ST_POLL) || (state == ST_XFER)) tmo_cnt <= tmo_cnt + 8'd1;
      if (cono_clr)     tmo_q <= 1'b0;
      else if (tmo_hit) tmo_q <= 1'b1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^8'(TMO_CYC);
  assign tmo_hit    = 1'b0;
  assign tmo        = 1'b0;
`endif

endmodule

// File: tb/tb_ebus_pi_agent.sv
// Directed self-checking bench for ebus_pi_agent (PHY_NO=5, PIA 3 service).
module tb_ebus_pi_agent;

  localparam int unsigned PHY    = 5;
  localparam logic [35:0] VEC    = 36'o123456701234;
  localparam int unsigned TMO    = 20;

  logic        clk = 1'b0;
  logic        RESET_N;
  logic        dev_irq;
  logic        cono_wr;
  logic [0:17] cono_data;
  logic        ebus_demand;
  logic [0:2]  ebus_func;
  logic [0:2]  ebus_pi_lvl;
  logic [0:35] ebus_data_in;
  logic [1:7]  pi_out;
  logic [0:35] ebus_data_out;
  logic        ebus_drive;
  logic        ebus_xfer;
  logic [0:2]  pia;
  logic [0:1]  pending;
  logic        tmo;

  int compared   = 0;
  int mismatched = 0;

  logic [0:35] poll_word;
  logic [0:35] vec_word;

  ebus_pi_agent #(.PHY_NO(PHY), .VECTOR(VEC), .TMO_CYC(TMO)) dut (
    .clk           (clk),
    .RESET_N       (RESET_N),
    .dev_irq       (dev_irq),
    .cono_wr       (cono_wr),
    .cono_data     (cono_data),
    .ebus_demand   (ebus_demand),
    .ebus_func     (ebus_func),
    .ebus_pi_lvl   (ebus_pi_lvl),
    .ebus_data_in  (ebus_data_in),
    .pi_out        (pi_out),
    .ebus_data_out (ebus_data_out),
    .ebus_drive    (ebus_drive),
    .ebus_xfer     (ebus_xfer),
    .pia           (pia),
    .pending       (pending),
    .tmo           (tmo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cono(input logic [2:0] p, input logic en, input logic clr, input logic irq);
    cono_data        = '0;
    cono_data[15:17] = p;
    cono_data[14]    = en;
    cono_data[13]    = clr;
    cono_wr          = 1'b1;
    dev_irq          = irq;
    tick();
    cono_wr = 1'b0;
    dev_irq = 1'b0;
  endtask

  task automatic drive_poll(input logic [2:0] lvl);
    ebus_demand = 1'b1;
    ebus_func   = 3'b001;
    ebus_pi_lvl = lvl;
  endtask

  task automatic drive_select(input logic [2:0] fn, input logic [3:0] phy);
    ebus_func          = 3'b010;
    ebus_data_in       = '0;
    ebus_data_in[3:5]  = fn;
    ebus_data_in[7:10] = phy;
  endtask

  task automatic release_bus();
    ebus_demand  = 1'b0;
    ebus_func    = '0;
    ebus_data_in = '0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    tick();
    tick();
    compared++;
    if (pi_out !== 7'b0) begin mismatched++; $display("FAIL reset_pi_out: got %b expected 0000000", pi_out); end
    compared++;
    if ({ebus_drive, ebus_xfer, tmo} !== 3'b000) begin mismatched++; $display("FAIL reset_ctl: got %b expected 000", {ebus_drive, ebus_xfer, tmo}); end
    compared++;
    if (ebus_data_out !== 36'd0) begin mismatched++; $display("FAIL reset_data: got %o expected 0", ebus_data_out); end
    compared++;
    if ({pia, pending} !== 5'd0) begin mismatched++; $display("FAIL reset_pia_pend: got %b expected 00000", {pia, pending}); end
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_basic_service();
    do_cono(3'd3, 1'b1, 1'b0, 1'b0);
    compared++;
    if (pia !== 3'd3) begin mismatched++; $display("FAIL cono_pia: got %0d expected 3", pia); end
    compared++;
    if (pi_out !== 7'b0) begin mismatched++; $display("FAIL idle_no_req: got %b expected 0000000", pi_out); end
    dev_irq = 1'b1;
    tick();
    dev_irq = 1'b0;
    compared++;
    if (pi_out !== 7'b0010000) begin mismatched++; $display("FAIL req_lvl3: got %b expected 0010000", pi_out); end
    drive_poll(3'd3);
    tick();
    compared++;
    if (ebus_drive !== 1'b1 || ebus_data_out !== poll_word) begin
      mismatched++; $display("FAIL poll_resp: got drive=%b data=%o expected drive=1 data=%o", ebus_drive, ebus_data_out, poll_word);
    end
    drive_select(3'b001, 4'(PHY));
    tick();
    tick();
    compared++;
    if (ebus_xfer !== 1'b1 || ebus_drive !== 1'b1 || ebus_data_out !== vec_word) begin
      mismatched++; $display("FAIL xfer_vector: got xfer=%b drive=%b data=%o expected 1 1 %o", ebus_xfer, ebus_drive, ebus_data_out, vec_word);
    end
    compared++;
    if (pi_out !== 7'b0) begin mismatched++; $display("FAIL xfer_no_req: got %b expected 0000000", pi_out); end
    release_bus();
    tick();
    compared++;
    if (ebus_xfer !== 1'b0 || pending !== 2'd0) begin
      mismatched++; $display("FAIL vector_done: got xfer=%b pending=%0d expected 0 0", ebus_xfer, pending);
    end
    tick();
    compared++;
    if (pi_out !== 7'b0) begin mismatched++; $display("FAIL req_cleared: got %b expected 0000000", pi_out); end
  endtask

  task automatic test_saturation();
    dev_irq = 1'b1;
    repeat (5) tick();
    dev_irq = 1'b0;
    compared++;
    if (pending !== 2'd3) begin mismatched++; $display("FAIL sat_count: got %0d expected 3", pending); end
    drive_poll(3'd3);
    tick();
    drive_select(3'b010, 4'(PHY));
    tick();
    tick();
    compared++;
    if (ebus_xfer !== 1'b1 || ebus_data_out !== 36'd0) begin
      mismatched++; $display("FAIL clear_xfer: got xfer=%b data=%o expected 1 0", ebus_xfer, ebus_data_out);
    end
    release_bus();
    tick();
    compared++;
    if (pending !== 2'd2) begin mismatched++; $display("FAIL clear_dec: got %0d expected 2", pending); end
    tick();
    compared++;
    if (pi_out !== 7'b0010000) begin mismatched++; $display("FAIL req_after_clear: got %b expected 0010000", pi_out); end
  endtask

  task automatic test_foreign_select();
    drive_poll(3'd3);
    tick();
    drive_select(3'b001, 4'(PHY + 1));
    tick();
    compared++;
    if (ebus_drive !== 1'b0 || ebus_xfer !== 1'b0) begin
      mismatched++; $display("FAIL foreign_release: got drive=%b xfer=%b expected 0 0", ebus_drive, ebus_xfer);
    end
    tick();
    compared++;
    if (ebus_xfer !== 1'b0 || pending !== 2'd2) begin
      mismatched++; $display("FAIL foreign_hold: got xfer=%b pending=%0d expected 0 2", ebus_xfer, pending);
    end
    release_bus();
    tick();
  endtask

  task automatic test_inert();
    drive_poll(3'd5);
    tick();
    compared++;
    if (ebus_drive !== 1'b0 || ebus_data_out !== 36'd0) begin
      mismatched++; $display("FAIL wrong_lvl_poll: got drive=%b data=%o expected 0 0", ebus_drive, ebus_data_out);
    end
    release_bus();
    tick();
    do_cono(3'd0, 1'b1, 1'b0, 1'b0);
    compared++;
    if (pi_out !== 7'b0 || pending !== 2'd2) begin
      mismatched++; $display("FAIL pia0_inert: got pi_out=%b pending=%0d expected 0000000 2", pi_out, pending);
    end
  endtask

  task automatic test_simultaneous();
    do_cono(3'd3, 1'b1, 1'b0, 1'b0);
    drive_poll(3'd3);
    tick();
    drive_select(3'b001, 4'(PHY));
    tick();
    tick();
    release_bus();
    dev_irq = 1'b1;
    tick();
    dev_irq = 1'b0;
    compared++;
    if (pending !== 2'd2) begin mismatched++; $display("FAIL inc_dec_same: got %0d expected 2", pending); end
    tick();
    do_cono(3'd3, 1'b1, 1'b1, 1'b1);
    compared++;
    if (pending !== 2'd0 || pi_out !== 7'b0) begin
      mismatched++; $display("FAIL clr_beats_irq: got pending=%0d pi_out=%b expected 0 0000000", pending, pi_out);
    end
  endtask

  task automatic test_reset_in_xfer();
    dev_irq = 1'b1;
    tick();
    dev_irq = 1'b0;
    drive_poll(3'd3);
    tick();
    drive_select(3'b001, 4'(PHY));
    tick();
    tick();
    compared++;
    if (ebus_xfer !== 1'b1) begin mismatched++; $display("FAIL pre_reset_xfer: got %b expected 1", ebus_xfer); end
    RESET_N = 1'b0;
    tick();
    compared++;
    if ({ebus_xfer, ebus_drive, pi_out, pending, pia} !== 14'd0 || ebus_data_out !== 36'd0) begin
      mismatched++; $display("FAIL reset_in_xfer: got xfer=%b drive=%b pi_out=%b pending=%0d pia=%0d data=%o expected all 0",
                             ebus_xfer, ebus_drive, pi_out, pending, pia, ebus_data_out);
    end
    RESET_N = 1'b1;
    release_bus();
    tick();
  endtask

  task automatic test_watchdog();
    bit released;
    do_cono(3'd3, 1'b1, 1'b0, 1'b0);
    dev_irq = 1'b1;
    tick();
    dev_irq = 1'b0;
    drive_poll(3'd3);
    tick();
    drive_select(3'b001, 4'(PHY));
    tick();
    tick();
`ifdef PI_AGENT_TIMEOUT_EN
    released = 1'b0;
    for (int i = 0; i < 4 * TMO + 10; i++) begin
      if (!released && ebus_xfer === 1'b0) released = 1'b1;
      if (!released) tick();
    end
    compared++;
    if (released !== 1'b1) begin mismatched++; $display("FAIL wdog_release: got %b expected 1", released); end
    compared++;
    if (tmo !== 1'b1 || pending !== 2'd1 || ebus_drive !== 1'b0) begin
      mismatched++; $display("FAIL wdog_state: got tmo=%b pending=%0d drive=%b expected 1 1 0", tmo, pending, ebus_drive);
    end
`else
    released = 1'b0;
    repeat (2 * TMO) begin
      tick();
      if (ebus_xfer !== 1'b1) released = 1'b1;
    end
    compared++;
    if (released !== 1'b0 || tmo !== 1'b0) begin
      mismatched++; $display("FAIL no_wdog_hold: got released=%b tmo=%b expected 0 0", released, tmo);
    end
`endif
    release_bus();
    tick();
    tick();
  endtask

  initial begin
    RESET_N      = 1'b0;
    dev_irq      = 1'b0;
    cono_wr      = 1'b0;
    cono_data    = '0;
    ebus_demand  = 1'b0;
    ebus_func    = '0;
    ebus_pi_lvl  = '0;
    ebus_data_in = '0;
    poll_word      = '0;
    poll_word[PHY] = 1'b1;
    vec_word       = VEC;

    test_reset();
    test_basic_service();
    test_saturation();
    test_foreign_select();
    test_inert();
    test_simultaneous();
    test_reset_in_xfer();
    test_watchdog();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
